// File: rtl/bounce_square_565.sv
// Pixel stage behind the 480p timing generator: draws a square that bounces diagonally on a flat background, RGB565 out.
// Optional white one-pixel frame around the active area when BOUNCE_BORDER_EN is defined.
module bounce_square_565 #(
    parameter int CORDW     = 10,
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int Q_SIZE    = 32,
    parameter int Q_SPEED   = 2,
    parameter int FRAME_DIV = 1
) (
    input  logic             PCLK,
    input  logic             RST_PCLK,
    input  logic [CORDW-1:0] SX,
    input  logic [CORDW-1:0] SY,
    input  logic             HSYNC_I,
    input  logic             VSYNC_I,
    input  logic             DE_I,
    output logic             HSYNC,
    output logic             VSYNC,
    output logic             DE,
    output logic [4:0]       RED,
    output logic [5:0]       GREEN,
    output logic [4:0]       BLUE
);
    localparam int EW = CORDW + 1;
    localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    localparam logic [EW-1:0] H_RES_E = EW'(H_RES);
    localparam logic [EW-1:0] V_RES_E = EW'(V_RES);
    localparam logic [EW-1:0] SIZE_E  = EW'(Q_SIZE);
    localparam logic [EW-1:0] SPEED_E = EW'(Q_SPEED);

    typedef enum logic {DIR_INC = 1'b0, DIR_DEC = 1'b1} dir_e;

    typedef struct packed {
        logic [CORDW-1:0] pos;
        dir_e             dir;
    } axis_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb_t;

    localparam rgb_t SQ_C = '{r: 5'h1F, g: 6'h2A, b: 5'h00};
    localparam rgb_t BG_C = '{r: 5'h02, g: 6'h05, b: 5'h0A};
`ifdef BOUNCE_BORDER_EN
    localparam rgb_t BD_C = '{r: 5'h1F, g: 6'h3F, b: 5'h1F};
`endif

    // One bounce step along an axis; arithmetic is one bit wider than the coordinate so the edge test never wraps.
    function automatic axis_t axis_step(input axis_t cur, input logic [EW-1:0] res);
        axis_t         nxt;
        logic [EW-1:0] p;
        p   = {1'b0, cur.pos};
        nxt = cur;
        if (cur.dir == DIR_INC) begin
            if (p + SIZE_E + SPEED_E >= res) begin
                nxt.pos = CORDW'(res - SIZE_E);
                nxt.dir = DIR_DEC;
            end else begin
                nxt.pos = CORDW'(p + SPEED_E);
            end
        end else begin
            if (p <= SPEED_E) begin
                nxt.pos = '0;
                nxt.dir = DIR_INC;
            end else begin
                nxt.pos = CORDW'(p - SPEED_E);
            end
        end
        return nxt;
    endfunction

    logic          tick_q, tick_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    axis_t         x_q, x_d, y_q, y_d;

    logic          in_sq_q, in_sq_d;
    logic          hs1_q, vs1_q, de1_q;
`ifdef BOUNCE_BORDER_EN
    logic          border_q, border_d;
`endif

    logic          hs2_q, vs2_q, de2_q;
    rgb_t          rgb_q, rgb_d;

    logic [EW-1:0] sx_e, sy_e, qx_e, qy_e;

    // NOTE: every always_comb output gets a default first, so no path can leave a signal unassigned and infer a latch.
    always_comb begin
        tick_d = (SX == '0) && (SY == CORDW'(V_RES));
        fcnt_d = fcnt_q;
        x_d    = x_q;
        y_d    = y_q;
        if (tick_q) begin
            if (fcnt_q == FW'(FRAME_DIV - 1)) begin
                fcnt_d = '0;
                x_d    = axis_step(x_q, H_RES_E);
                y_d    = axis_step(y_q, V_RES_E);
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end

        sx_e    = {1'b0, SX};
        sy_e    = {1'b0, SY};
        qx_e    = {1'b0, x_q.pos};
        qy_e    = {1'b0, y_q.pos};
        in_sq_d = (sx_e >= qx_e) && (sx_e < qx_e + SIZE_E) &&
                  (sy_e >= qy_e) && (sy_e < qy_e + SIZE_E);
`ifdef BOUNCE_BORDER_EN
        border_d = (SX == '0) || (SX == CORDW'(H_RES - 1)) ||
                   (SY == '0) || (SY == CORDW'(V_RES - 1));
`endif

        rgb_d = '0;
        if (de1_q) begin
            rgb_d = in_sq_q ? SQ_C : BG_C;
`ifdef BOUNCE_BORDER_EN
            if (border_q) rgb_d = BD_C;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge value of its neighbours.
    always_ff @(posedge PCLK) begin
        if (RST_PCLK) begin
            tick_q   <= 1'b0;
            fcnt_q   <= '0;
            x_q      <= '{pos: '0, dir: DIR_INC};
            y_q      <= '{pos: '0, dir: DIR_INC};
            in_sq_q  <= 1'b0;
            hs1_q    <= 1'b0;
            vs1_q    <= 1'b0;
            de1_q    <= 1'b0;
`ifdef BOUNCE_BORDER_EN
            border_q <= 1'b0;
`endif
            hs2_q    <= 1'b0;
            vs2_q    <= 1'b0;
            de2_q    <= 1'b0;
            rgb_q    <= '0;
        end else begin
            tick_q   <= tick_d;
            fcnt_q   <= fcnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            in_sq_q  <= in_sq_d;
            hs1_q    <= HSYNC_I;
            vs1_q    <= VSYNC_I;
            de1_q    <= DE_I;
`ifdef BOUNCE_BORDER_EN
            border_q <= border_d;
`endif
            hs2_q    <= hs1_q;
            vs2_q    <= vs1_q;
            de2_q    <= de1_q;
            rgb_q    <= rgb_d;
        end
    end

    assign HSYNC = hs2_q;
    assign VSYNC = vs2_q;
    assign DE    = de2_q;
    assign RED   = rgb_q.r;
    assign GREEN = rgb_q.g;
    assign BLUE  = rgb_q.b;

endmodule

// File: tb/tb_bounce_square_565.sv
// Bench for bounce_square_565: triangle-wave position model with a per-cycle compare, plus literal pixel probes
// on three instances (defaults, 480x480 screen, FRAME_DIV=3).
module tb_bounce_square_565;

    localparam logic [15:0] SQ = 16'hFD40;
    localparam logic [15:0] BG = 16'h10AA;
    localparam logic [15:0] WH = 16'hFFFF;

    logic       pclk = 1'b0;
    logic       rst  = 1'b1;
    logic [9:0] sx, sy;
    logic       hs_i, vs_i, de_i;

    logic       hs_a, vs_a, de_a, hs_b, vs_b, de_b, hs_c, vs_c, de_c;
    logic [4:0] r_a, b_a, r_b, b_b, r_c, b_c;
    logic [5:0] g_a, g_b, g_c;

    int n_checks = 0;
    int n_errors = 0;

    always #5 pclk = ~pclk;

    bounce_square_565 dut (
        .PCLK(pclk), .RST_PCLK(rst), .SX(sx), .SY(sy),
        .HSYNC_I(hs_i), .VSYNC_I(vs_i), .DE_I(de_i),
        .HSYNC(hs_a), .VSYNC(vs_a), .DE(de_a), .RED(r_a), .GREEN(g_a), .BLUE(b_a)
    );

    bounce_square_565 #(.H_RES(480)) dut_sq480 (
        .PCLK(pclk), .RST_PCLK(rst), .SX(sx), .SY(sy),
        .HSYNC_I(hs_i), .VSYNC_I(vs_i), .DE_I(de_i),
        .HSYNC(hs_b), .VSYNC(vs_b), .DE(de_b), .RED(r_b), .GREEN(g_b), .BLUE(b_b)
    );

    bounce_square_565 #(.FRAME_DIV(3)) dut_div3 (
        .PCLK(pclk), .RST_PCLK(rst), .SX(sx), .SY(sy),
        .HSYNC_I(hs_i), .VSYNC_I(vs_i), .DE_I(de_i),
        .HSYNC(hs_c), .VSYNC(vs_c), .DE(de_c), .RED(r_c), .GREEN(g_c), .BLUE(b_c)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Position after n updates: a triangle wave between 0 and maxp (exact while maxp is a multiple of spd).
    function automatic int tri_pos(input int n, input int maxp, input int spd);
        int p;
        p = (n * spd) % (2 * maxp);
        return (p > maxp) ? 2 * maxp - p : p;
    endfunction

    function automatic logic [15:0] pix(input int x, input int y, input logic de, input int qx, input int qy);
        if (!de) return 16'h0000;
`ifdef BOUNCE_BORDER_EN
        if (x == 0 || x == 639 || y == 0 || y == 479) return WH;
`endif
        if (x >= qx && x < qx + 32 && y >= qy && y < qy + 32) return SQ;
        return BG;
    endfunction

    // Model of the default instance: count frame-tick conditions, derive the square from the count.
    logic [18:0] m_stage = '0;
    logic [18:0] m_exp   = '0;
    int          m_ticks = 0;
    logic        m_pend  = 1'b0;
    logic        m_live  = 1'b0;

    always @(posedge pclk) begin
        if (rst) begin
            m_ticks = 0;
            m_pend  = 1'b0;
            m_stage = '0;
            m_exp   = '0;
            m_live  = 1'b1;
        end else begin
            m_exp   = m_stage;
            m_stage = {hs_i, vs_i, de_i,
                       pix(int'(sx), int'(sy), de_i, tri_pos(m_ticks, 608, 2), tri_pos(m_ticks, 448, 2))};
            if (m_pend) m_ticks++;
            m_pend = (sx == 10'd0) && (sy == 10'd480);
        end
    end

    always @(negedge pclk) begin
        if (m_live) begin
            check("pipe", 32'({hs_a, vs_a, de_a, r_a, g_a, b_a}), 32'(m_exp));
            check("sync_sq480", 32'({hs_b, vs_b, de_b}), 32'(m_exp[18:16]));
            check("sync_div3", 32'({hs_c, vs_c, de_c}), 32'(m_exp[18:16]));
            if (!de_a) check("blank_rgb", 32'({r_a, g_a, b_a}), 32'd0);
        end
    end

    task automatic cyc(input int x, input int y, input logic de, input logic hs, input logic vs);
        sx   = 10'(x);
        sy   = 10'(y);
        de_i = de;
        hs_i = hs;
        vs_i = vs;
        @(posedge pclk);
        #2;
    endtask

    task automatic frame_tick();
        cyc(0, 480, 1'b0, 1'b1, 1'b1);
        cyc(1, 481, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic probe(input int x, input int y, output logic [15:0] ca, output logic [15:0] cb,
                         output logic [15:0] cc);
        cyc(x, y, 1'b1, 1'b0, 1'b0);
        cyc(1, 481, 1'b0, 1'b0, 1'b0);
        @(negedge pclk);
        ca = {r_a, g_a, b_a};
        cb = {r_b, g_b, b_b};
        cc = {r_c, g_c, b_c};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1, 481, 1'b1, 1'b1, 1'b1);
        @(negedge pclk);
        check("rst_mid_out", 32'({hs_a, vs_a, de_a, r_a, g_a, b_a}), 32'd0);
        rst = 1'b0;
    endtask

    // Square side probe for the FRAME_DIV=3 instance at position q (both axes equal).
    task automatic div3_probe(input string tag, input int q);
        logic [15:0] ca, cb, cc;
        probe(q + 31, q + 5, ca, cb, cc);
        check({tag, "_in"}, 32'(cc), 32'(SQ));
        probe(q + 32, q + 5, ca, cb, cc);
        check({tag, "_out"}, 32'(cc), 32'(BG));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          q3_exp[9] = '{0, 0, 2, 2, 2, 4, 4, 4, 6};
        logic [15:0] ca, cb, cc;

        sx = 10'd5; sy = 10'd5; de_i = 1'b1; hs_i = 1'b0; vs_i = 1'b0;
        repeat (3) begin
            @(posedge pclk);
            @(negedge pclk);
            check("rst_hold", 32'({hs_a, vs_a, de_a, r_a, g_a, b_a}), 32'd0);
        end
        rst = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        check("fill_first", 32'({de_a, r_a, g_a, b_a}), 32'd0);
        repeat (2) begin
            @(posedge pclk);
            @(negedge pclk);
        end
        check("first_sq", 32'({r_a, g_a, b_a}), 32'(SQ));
        check("first_sq_480", 32'({r_b, g_b, b_b}), 32'(SQ));
        check("first_sq_div3", 32'({r_c, g_c, b_c}), 32'(SQ));

`ifdef BOUNCE_BORDER_EN
        probe(0, 100, ca, cb, cc);  check("edge_left", 32'(ca), 32'(WH));
        probe(0, 10, ca, cb, cc);   check("edge_over_sq", 32'(ca), 32'(WH));
        check("edge_over_sq_div3", 32'(cc), 32'(WH));
        probe(639, 479, ca, cb, cc); check("edge_corner", 32'(ca), 32'(WH));
`else
        probe(0, 100, ca, cb, cc);  check("edge_left", 32'(ca), 32'(BG));
        probe(0, 10, ca, cb, cc);   check("edge_over_sq", 32'(ca), 32'(SQ));
        check("edge_over_sq_div3", 32'(cc), 32'(SQ));
        probe(639, 479, ca, cb, cc); check("edge_corner", 32'(ca), 32'(BG));
`endif

        for (int i = 0; i < 48; i++) begin
            cyc(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        for (int t = 1; t <= 9; t++) begin
            frame_tick();
            div3_probe($sformatf("div3_t%0d", t), q3_exp[t-1]);
        end
        do_reset();
        repeat (4) frame_tick();
        div3_probe("div3_pre_rst", 2);
        do_reset();
        div3_probe("div3_after_rst", 0);
        for (int t = 1; t <= 3; t++) begin
            frame_tick();
            div3_probe($sformatf("div3_r%0d", t), q3_exp[t-1]);
        end

        do_reset();
        for (int t = 1; t <= 305; t++) begin
            frame_tick();
            if (t == 224) begin
                probe(460, 447, ca, cb, cc); check("t224_a_top", 32'(ca), 32'(BG)); check("t224_b_top", 32'(cb), 32'(BG));
                probe(460, 448, ca, cb, cc); check("t224_a_in", 32'(ca), 32'(SQ));  check("t224_b_in", 32'(cb), 32'(SQ));
                probe(447, 460, ca, cb, cc); check("t224_a_lft", 32'(ca), 32'(BG)); check("t224_b_lft", 32'(cb), 32'(BG));
            end
            if (t == 225) begin
                probe(446, 446, ca, cb, cc); check("t225_b_corner", 32'(cb), 32'(SQ)); check("t225_a_corner", 32'(ca), 32'(BG));
                probe(445, 450, ca, cb, cc); check("t225_b_lft", 32'(cb), 32'(BG));
                probe(450, 445, ca, cb, cc); check("t225_b_top", 32'(cb), 32'(BG));
                probe(477, 477, ca, cb, cc); check("t225_b_far", 32'(cb), 32'(SQ)); check("t225_a_far", 32'(ca), 32'(SQ));
                probe(478, 470, ca, cb, cc); check("t225_b_rgt", 32'(cb), 32'(BG)); check("t225_a_mid", 32'(ca), 32'(SQ));
            end
            if (t == 303) begin
                probe(605, 300, ca, cb, cc); check("t303_lft", 32'(ca), 32'(BG));
                probe(606, 300, ca, cb, cc); check("t303_in", 32'(ca), 32'(SQ));
            end
            if (t == 304) begin
                probe(607, 300, ca, cb, cc); check("t304_lft", 32'(ca), 32'(BG));
                probe(608, 300, ca, cb, cc); check("t304_in", 32'(ca), 32'(SQ));
                probe(638, 300, ca, cb, cc); check("t304_rgt", 32'(ca), 32'(SQ));
            end
            if (t == 305) begin
                probe(605, 300, ca, cb, cc); check("t305_lft", 32'(ca), 32'(BG));
                probe(606, 300, ca, cb, cc); check("t305_in", 32'(ca), 32'(SQ));
                probe(638, 300, ca, cb, cc); check("t305_rgt", 32'(ca), 32'(BG));
            end
        end

        repeat (3) cyc(1, 481, 1'b0, 1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
